ksa4_pipe_adder: RTL and testbench

//   4-bit Kogge-Stone adder with carry-in and carry-out. Fully pipelined.

---
 rtl/ksa4_pipe_adder.sv | 119 +++++++++++
 tb/tb_ksa4_pipe_adder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ksa4_pipe_adder.sv
// 4-bit Kogge-Stone adder with carry-in, four register stages, pad-level I/O.
// Optional signed-overflow output ovf_Pad is enabled by defining KSA4_OVF_EN.
module ksa4_pipe_adder (
  input  logic GCLK_Pad,
  input  logic RSTN_Pad,
  input  logic a0_Pad,
  input  logic a1_Pad,
  input  logic a2_Pad,
  input  logic a3_Pad,
  input  logic b0_Pad,
  input  logic b1_Pad,
  input  logic b2_Pad,
  input  logic b3_Pad,
  input  logic cin_Pad,
  output logic sum0_Pad,
  output logic sum1_Pad,
  output logic sum2_Pad,
  output logic sum3_Pad,
  output logic cout_Pad
`ifdef KSA4_OVF_EN
  ,
  output logic ovf_Pad
`endif
);

  logic [3:0] a, b;
  assign a = {a3_Pad, a2_Pad, a1_Pad, a0_Pad};
  assign b = {b3_Pad, b2_Pad, b1_Pad, b0_Pad};

  // Stage 1: bitwise propagate/generate, carry-in acts as g at position -1.
  logic [3:0] p1_q, g1_q;
  logic       c1_q;

  // Stage 2: prefix level 1 (span 1). Position 0 pairs with cin, so P is 0 there.
  logic [3:0] gl1_d, gl1_q;
  logic [3:1] pl1_d, pl1_q;
  logic [3:0] p2_q;
  logic       c2_q;

  // Stage 3: prefix level 2 (span 2); carry_q[i] is the carry out of bit i.
  logic [3:0] carry_d, carry_q;
  logic [3:0] p3_q;
  logic       c3_q;

  // Stage 4: registered outputs.
  logic [3:0] sum_d, sum_q;
  logic       cout_q;
`ifdef KSA4_OVF_EN
  logic       ovf_q;
`endif

  always_comb begin
    gl1_d[0] = g1_q[0] | (p1_q[0] & c1_q);
    for (int i = 1; i < 4; i++) begin
      gl1_d[i] = g1_q[i] | (p1_q[i] & g1_q[i-1]);
      pl1_d[i] = p1_q[i] & p1_q[i-1];
    end
  end

  // Position 3 spans five inputs (bits 3..0 plus cin); the span-2 group at
  // position 1 lacks cin, so its propagate term is extended by p1:p0 & cin.
  always_comb begin
    carry_d[0] = gl1_q[0];
    carry_d[1] = gl1_q[1] | (pl1_q[1] & c2_q);
    carry_d[2] = gl1_q[2] | (pl1_q[2] & gl1_q[0]);
    carry_d[3] = gl1_q[3] | (pl1_q[3] & gl1_q[1]) | (pl1_q[3] & pl1_q[1] & c2_q);
  end

  always_comb begin
    sum_d[0]   = p3_q[0] ^ c3_q;
    sum_d[3:1] = p3_q[3:1] ^ carry_q[2:0];
  end

  always_ff @(posedge GCLK_Pad or negedge RSTN_Pad) begin
    if (!RSTN_Pad) begin
      p1_q    <= '0;
      g1_q    <= '0;
      c1_q    <= 1'b0;
      gl1_q   <= '0;
      pl1_q   <= '0;
      p2_q    <= '0;
      c2_q    <= 1'b0;
      carry_q <= '0;
      p3_q    <= '0;
      c3_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef KSA4_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      p1_q    <= a ^ b;
      g1_q    <= a & b;
      c1_q    <= cin_Pad;
      gl1_q   <= gl1_d;
      pl1_q   <= pl1_d;
      p2_q    <= p1_q;
      c2_q    <= c1_q;
      carry_q <= carry_d;
      p3_q    <= p2_q;
      c3_q    <= c2_q;
      sum_q   <= sum_d;
      cout_q  <= carry_q[3];
`ifdef KSA4_OVF_EN
      ovf_q   <= carry_q[3] ^ carry_q[2];
`endif
    end
  end

  assign sum0_Pad = sum_q[0];
  assign sum1_Pad = sum_q[1];
  assign sum2_Pad = sum_q[2];
  assign sum3_Pad = sum_q[3];
  assign cout_Pad = cout_q;
`ifdef KSA4_OVF_EN
  assign ovf_Pad  = ovf_q;
`endif

endmodule

// File: tb/tb_ksa4_pipe_adder.sv
// Directed-vector bench for ksa4_pipe_adder; checks {ovf,cout,sum} four edges after capture.
module tb_ksa4_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] a, b;
  logic cin;
  logic sum0, sum1, sum2, sum3, cout;
  logic ovf;

  always #5 clk = ~clk;

  ksa4_pipe_adder u_dut (
    .GCLK_Pad (clk),
    .RSTN_Pad (rst_n),
    .a0_Pad   (a[0]),
    .a1_Pad   (a[1]),
    .a2_Pad   (a[2]),
    .a3_Pad   (a[3]),
    .b0_Pad   (b[0]),
    .b1_Pad   (b[1]),
    .b2_Pad   (b[2]),
    .b3_Pad   (b[3]),
    .cin_Pad  (cin),
    .sum0_Pad (sum0),
    .sum1_Pad (sum1),
    .sum2_Pad (sum2),
    .sum3_Pad (sum3),
    .cout_Pad (cout)
`ifdef KSA4_OVF_EN
    ,
    .ovf_Pad  (ovf)
`endif
  );

`ifndef KSA4_OVF_EN
  assign ovf = 1'b0;
`endif

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] res;  // {cout, sum}
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] observe();
    return {ovf, cout, sum3, sum2, sum1, sum0};
  endfunction

  // Without the overflow option the ovf bit of the expectation is always 0.
  function automatic logic [5:0] expect_of(input vec_t v);
`ifdef KSA4_OVF_EN
    return {v.ovf, v.res};
`else
    return {1'b0, v.res};
`endif
  endfunction

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    a   = ta;
    b   = tb;
    cin = tc;
  endtask

  initial begin
    vec_t z;
    vec_t v;
    z = '{a: 4'd0, b: 4'd0, c: 1'b0, res: 5'b00000, ovf: 1'b0};

    vecs.push_back('{a: 4'd12, b: 4'd12, c: 1'b0, res: 5'b11000, ovf: 1'b0});
    vecs.push_back(z);
    vecs.push_back('{a: 4'd7,  b: 4'd7,  c: 1'b0, res: 5'b01110, ovf: 1'b1});
    vecs.push_back('{a: 4'd12, b: 4'd8,  c: 1'b0, res: 5'b10100, ovf: 1'b1});
    vecs.push_back('{a: 4'd2,  b: 4'd6,  c: 1'b1, res: 5'b01001, ovf: 1'b1});
    vecs.push_back('{a: 4'd14, b: 4'd4,  c: 1'b1, res: 5'b10011, ovf: 1'b0});
    vecs.push_back('{a: 4'd15, b: 4'd15, c: 1'b1, res: 5'b11111, ovf: 1'b0});
    vecs.push_back('{a: 4'd15, b: 4'd0,  c: 1'b1, res: 5'b10000, ovf: 1'b0});
    vecs.push_back('{a: 4'd5,  b: 4'd10, c: 1'b0, res: 5'b01111, ovf: 1'b0});
    vecs.push_back('{a: 4'd7,  b: 4'd1,  c: 1'b0, res: 5'b01000, ovf: 1'b1});
    vecs.push_back('{a: 4'd8,  b: 4'd8,  c: 1'b0, res: 5'b10000, ovf: 1'b1});
    vecs.push_back('{a: 4'd3,  b: 4'd2,  c: 1'b0, res: 5'b00101, ovf: 1'b0});
    for (int i = 0; i < 4; i++) vecs.push_back(z);

    rst_n = 1'b0;
    drive(4'd0, 4'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("in_reset", observe(), 6'd0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_after_reset", observe(), 6'd0);
    end

    // Vector k is driven at negedge k and must appear at negedge k+4.
    for (int k = 0; k < vecs.size() + 4; k++) begin
      @(negedge clk);
      if (k >= 4) check($sformatf("vec%0d", k - 4), observe(), expect_of(vecs[k-4]));
      else        check("pipe_fill", observe(), 6'd0);
      if (k < vecs.size()) begin
        v = vecs[k];
        drive(v.a, v.b, v.c);
      end else begin
        drive(4'd0, 4'd0, 1'b0);
      end
    end

    // Reset mid-flight: op0 reaches the outputs while three more are in the pipe.
    @(negedge clk);
    drive(4'd15, 4'd15, 1'b1);
    @(negedge clk);
    drive(4'd9, 4'd6, 1'b0);
    @(negedge clk);
    drive(4'd12, 4'd12, 1'b0);
    @(negedge clk);
    drive(4'd7, 4'd8, 1'b1);
    @(posedge clk);
    #1;
`ifdef KSA4_OVF_EN
    check("pre_reset_result", observe(), 6'b011111);
`else
    check("pre_reset_result", observe(), 6'b011111);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", observe(), 6'd0);
    drive(4'd0, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("held_in_reset", observe(), 6'd0);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_stale_after_reset", observe(), 6'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
